// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, sizing helper and default parameters for fifo_wr_arbiter.
package fifo_arb_pkg;

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_NREQ      = 4;
   localparam int DEF_BURST_LEN = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotating-priority selector; returns the first set request at or after rr, wrapping.
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IW   = clog2(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   rr,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Scan from the lowest priority down so the closest request to rr wins.
   always_comb begin
      idx = '0;
      any = |req;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[(int'(rr) + i) % NREQ]) idx = IW'((int'(rr) + i) % NREQ);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst write arbiter sharing one FIFO write port among NREQ producers.
// Define FIFO_WR_ARBITER_AFULL_THROTTLE_EN to hold off new grants while the FIFO is almost full.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NREQ      = DEF_NREQ,
   parameter int BURST_LEN = DEF_BURST_LEN
)(
   input  logic                  I_CLK,
   input  logic                  I_RESET,
   input  logic [NREQ-1:0]       I_REQ_VALID,
   input  logic [NREQ*WIDTH-1:0] I_REQ_DATA,
   output logic [NREQ-1:0]       O_REQ_READY,
   input  logic                  I_FIFO_FULL,
   input  logic                  I_FIFO_AFULL,
   output logic                  O_FIFO_WE,
   output logic [WIDTH-1:0]      O_FIFO_DIN,
   output logic [NREQ-1:0]       O_GRANT,
   output logic                  O_BUSY
);

   localparam int IW = clog2(NREQ);
   localparam int BW = clog2(BURST_LEN) + 1;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IW-1:0]   g_q, g_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [BW-1:0]   bc_q, bc_d;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            launch;
   logic            busy;
   logic            valid_g;
   logic            open;

   rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req (I_REQ_VALID),
      .rr  (rr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

`ifdef FIFO_WR_ARBITER_AFULL_THROTTLE_EN
   assign launch = pick_any & ~I_FIFO_AFULL;
`else
   logic unused_afull;
   assign unused_afull = I_FIFO_AFULL;
   assign launch       = pick_any;
`endif

   assign busy        = state_q == ST_BURST;
   assign valid_g     = I_REQ_VALID[g_q];
   assign open        = busy & ~I_FIFO_FULL & ~I_RESET;
   assign O_FIFO_WE   = open & valid_g;
   assign O_REQ_READY = open ? NREQ'(1) << g_q : '0;
   assign O_FIFO_DIN  = I_REQ_DATA[int'(g_q)*WIDTH +: WIDTH];
   assign O_GRANT     = grant_q;
   assign O_BUSY      = busy;

   // A FULL stall leaves every register untouched, so the grant survives a valid drop until FULL clears.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      g_d     = g_q;
      rr_d    = rr_q;
      bc_d    = bc_q;
      if (!busy) begin
         if (launch) begin
            state_d = ST_BURST;
            g_d     = pick_idx;
            grant_d = NREQ'(1) << pick_idx;
            bc_d    = '0;
         end
      end else begin
         bc_d = O_FIFO_WE ? bc_q + BW'(1) : bc_q;
         if ((O_FIFO_WE & (bc_q == BW'(BURST_LEN - 1))) | (~valid_g & ~I_FIFO_FULL)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
         end
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         g_q     <= '0;
         rr_q    <= '0;
         bc_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
         bc_q    <= bc_d;
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter and burst scheduler that shares the write port of one synchronous FIFO among NREQ producers. Each producer offers words through a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_LEN words and drives the FIFO write enable and data. It sits directly in front of the FIFO and uses the FIFO's FULL and AFULL status for flow control.

## Interface
- WIDTH, 8, data word width; must equal the FIFO WIDTH.
- NREQ, 4, number of requesters, 2..16.
- BURST_LEN, 4, maximum number of words written per grant, 1..16.

- I_CLK  in  1  clock; all logic is on the rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_REQ_VALID  in  NREQ  per-requester word valid.
- I_REQ_DATA  in  NREQ*WIDTH  requester k data is in bits [k*WIDTH +: WIDTH].
- O_REQ_READY  out  NREQ  per-requester ready; a word transfers when valid and ready are both high.
- I_FIFO_FULL  in  1  FIFO O_FULL.
- I_FIFO_AFULL  in  1  FIFO O_AFULL.
- O_FIFO_WE  out  1  FIFO I_WE.
- O_FIFO_DIN  out  WIDTH  FIFO I_DIN.
- O_GRANT  out  NREQ  one-hot current grant, registered.
- O_BUSY  out  1  high in the BURST state.

## Operation
- The FSM has two states, IDLE and BURST.
- Registers:
  - state
  - O_GRANT
  - grant index g (clog2(NREQ) bits)
  - round-robin pointer rr (clog2(NREQ) bits)
  - beat counter bc (clog2(BURST_LEN)+1 bits)
- IDLE:
  - If any I_REQ_VALID is high, select the first requester at or after rr in ascending order, wrapping past the top.
  - Load g and O_GRANT, clear bc, and go to BURST.
  - No writes happen in IDLE.
- BURST, combinational outputs:
  - O_FIFO_WE = I_REQ_VALID[g] & ~I_FIFO_FULL & ~I_RESET.
  - O_REQ_READY[g] = ~I_FIFO_FULL & ~I_RESET. All other ready bits are 0.
  - O_FIFO_DIN = I_REQ_DATA[g], always muxed; the value is don't-care when WE is low.
- BURST, updates:
  - Each write increments bc.
  - FULL stalls: WE is low, bc holds, and the grant is held indefinitely.
- Burst ends on the first of these:
  - A write occurs with bc == BURST_LEN-1.
  - I_REQ_VALID[g] is low while the FIFO is not full. The producer has released; no write happens that cycle.
- On burst end:
  - rr = (g+1) mod NREQ.
  - O_GRANT is cleared and the FSM returns to IDLE.
  - There is a mandatory one-cycle bubble between bursts.
- A requester that deasserts valid while stalled on FULL keeps the grant until FULL clears.
- Simultaneous FIFO reads are outside this block. FULL deasserting is the only coupling.

## Timing
- Reset values: state=IDLE, O_GRANT=0, g=0, rr=0, bc=0, O_BUSY=0, O_FIFO_WE=0, O_REQ_READY=0, O_FIFO_DIN=I_REQ_DATA[0].
- Latency: valid rising in IDLE at edge n gives grant at edge n+1 and the first write at edge n+2.
- Sustained throughput: BURST_LEN writes per BURST_LEN+1 cycles.
- Reset mid-burst:
  - O_FIFO_WE and O_REQ_READY are forced low in the reset cycle.
  - All registers take their reset values at that edge.
  - No partial beat is written.

## Configuration
- Macro: FIFO_WR_ARBITER_AFULL_THROTTLE_EN.
- Defined: in IDLE, no new grant is issued while I_FIFO_AFULL is high. An ongoing burst is unaffected.
- Undefined: I_FIFO_AFULL is ignored and may be left unconnected; grants depend only on valid.

## Structure
- Shared package fifo_arb_pkg holds:
  - state enum {ST_IDLE, ST_BURST}
  - clog2 helper function
  - default parameter constants
- Sub-module rr_priority_pick: combinational rotating-priority selector.
  - Inputs: request vector, rr.
  - Outputs: index, any-request flag.

## Test plan
Defaults apply: NREQ=4, BURST_LEN=4, FIFO DEPTH=10.
- Single producer, over-length burst: req0 offers 0x10..0x15, FIFO empty.
  - Writes 0x10..0x13 on consecutive cycles.
  - One bubble, then re-grant to req0.
  - Writes 0x14, 0x15, then IDLE.
- Fairness: all 4 valid continuously.
  - Grant order is 0,1,2,3,0.
  - Each grant gives 4 writes followed by 1 idle cycle.
- Full stall: 10 words written, FULL high.
  - WE=0 and ready=0, with bc and grant held.
  - One FIFO read clears FULL, and exactly one write follows.
- Early release: req1 drops valid after 2 beats.
  - Burst ends with rr=2.
  - req2 is granted next, even though req0 is still valid.
- Reset mid-burst after 2 beats of req2: I_RESET high for one cycle.
  - No write in that cycle; O_GRANT=0, O_BUSY=0, rr=0.
  - req0 wins next.
- Macro: AFULL=1 in IDLE with req3 valid.
  - Defined: no grant until AFULL drops.
  - Undefined: grant next cycle.
